// File: rtl/fp_divide32_pkg.sv
// Shared FP32 divider types and constants.
// Operand/result layouts, qNaN template and the mantissa decomposer.
package fp_divide32_pkg;

  localparam int EMSB  = 7;
  localparam int FMSB  = 22;
  localparam int FX    = 47;
  localparam int EX    = 56;
  localparam int BIAS  = 127;
  localparam int DELAY = 47;

  typedef struct packed {
    logic            sign;
    logic [EMSB:0]   exp;
    logic [FMSB:0]   frac;
  } fp32_t;

  typedef struct packed {
    logic            sign;
    logic [EMSB:0]   exp;
    logic [FX:0]     sig;
  } fpx_t;

  localparam logic [FX:0] QNAN_SIG =
    {1'b1, 23'h400004, 24'h0};

  // Denormals flush to zero, so the hidden bit
  // only exists for a non-zero exponent.
  function automatic logic [FMSB+1:0] fp_mant(
    input fp32_t x
  );
    return (x.exp == '0) ? '0 : {1'b1, x.frac};
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Restoring radix-2 significand divider, one quotient bit per clock.
// Ports: load/step control, fa/fb mantissas, q quotient, rem_nz, last.
module fp_div_core
  import fp_divide32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            load,
  input  logic            step,
  input  logic [FMSB+1:0] fa,
  input  logic [FMSB+1:0] fb,
  output logic [FX-1:0]   q,
  output logic            rem_nz,
  output logic            last
);

  logic [FMSB+2:0] rem;
  logic [FMSB+3:0] trial;
  logic [5:0]      cnt;
  logic            ge;

  // The remainder starts as fa itself (fa < 2*fb), so
  // the first trial yields the integer quotient bit.
  assign trial  = {1'b0, rem} - {2'b00, fb};
  assign ge     = ~trial[FMSB+3];
  assign last   = (cnt == '0);
  assign rem_nz = |rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (ce) begin
      if (load) begin
        rem <= {1'b0, fa};
        q   <= '0;
        cnt <= 6'(DELAY - 1);
      end else if (step) begin
        if (ge) rem <= {trial[FMSB+1:0], 1'b0};
        else    rem <= {rem[FMSB+1:0], 1'b0};
        q   <= {q[FX-2:0], ge};
        cnt <= cnt - 6'd1;
      end
    end
  end

endmodule

// File: rtl/fp_divide32_seq.sv
// Iterative FP32 divider producing the expanded {sign,exp,sig48} format.
// Ports: clk, rst_n, ce, ld, a, b in; o, busy, done, inf/overflow/underflow/dbz out.
module fp_divide32_seq
  import fp_divide32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        ld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [EX:0] o,
  output logic        busy,
  output logic        done,
  output logic        inf,
  output logic        overflow,
  output logic        underflow,
  output logic        dbz
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  fp32_t            a_r, b_r;
  logic             accept, step;
  logic             last, rem_nz;
  logic [FX-1:0]    q;
  logic [FMSB+1:0]  ma_in, mb;
  logic signed [9:0] ex;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  fpx_t res;
  logic r_inf, r_ovf, r_unf, r_dbz;

  assign accept = ld &&
    (state == S_IDLE || state == S_DONE);
  assign step   = (state == S_DIV);
  assign ma_in  = fp_mant(fp32_t'(a));
  assign mb     = fp_mant(b_r);

  fp_div_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .load   (accept),
    .step   (step),
    .fa     (ma_in),
    .fb     (mb),
    .q      (q),
    .rem_nz (rem_nz),
    .last   (last)
  );

  assign a_zero = (a_r.exp == '0);
  assign a_inf  = (&a_r.exp) && (a_r.frac == '0);
  assign a_nan  = (&a_r.exp) && (a_r.frac != '0);
  assign b_zero = (b_r.exp == '0);
  assign b_inf  = (&b_r.exp) && (b_r.frac == '0);
  assign b_nan  = (&b_r.exp) && (b_r.frac != '0);

  assign ex = $signed({2'b00, a_r.exp})
            - $signed({2'b00, b_r.exp})
            + 10'sd127;

  // Special cases are checked in priority order;
  // the iteration result is used only when none hit.
  always_comb begin
    res.sign = a_r.sign ^ b_r.sign;
    res.exp  = ex[7:0];
    res.sig  = {1'b0, q[FX-1:1], q[0] | rem_nz};
    r_inf    = 1'b0;
    r_ovf    = 1'b0;
    r_unf    = 1'b0;
    r_dbz    = 1'b0;
    if (a_nan) begin
      res.exp = '1;
      res.sig = {1'b1, 1'b1, a_r.frac[FMSB-1:0], 24'h0};
    end else if (b_nan) begin
      res.exp = '1;
      res.sig = {1'b1, 1'b1, b_r.frac[FMSB-1:0], 24'h0};
    end else if ((a_inf && b_inf) ||
                 (a_zero && b_zero)) begin
      res.exp = '1;
      res.sig = QNAN_SIG;
    end else if (a_inf) begin
      res.exp = '1;
      res.sig = '0;
      r_inf   = 1'b1;
    end else if (b_zero) begin
      res.exp = '1;
      res.sig = '0;
      r_inf   = 1'b1;
      r_dbz   = 1'b1;
    end else if (a_zero || b_inf) begin
      res.exp = '0;
      res.sig = '0;
    end else if (ex >= 10'sd255) begin
      res.exp = '1;
      res.sig = '0;
      r_ovf   = 1'b1;
      r_inf   = 1'b1;
    end else if (ex[9]) begin
      res.exp = '0;
      res.sig = '0;
      r_unf   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      o         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inf       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dbz       <= 1'b0;
    end else if (ce) begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (ld) begin
            state     <= S_DIV;
            a_r       <= a;
            b_r       <= b;
            o         <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            inf       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dbz       <= 1'b0;
          end
        end
        S_DIV: begin
          if (last) state <= S_FINAL;
        end
        S_FINAL: begin
          state     <= S_DONE;
          o         <= res;
          busy      <= 1'b0;
          done      <= 1'b1;
          inf       <= r_inf;
          overflow  <= r_ovf;
          underflow <= r_unf;
          dbz       <= r_dbz;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_divide32_seq.md
# fp_divide32_seq

Iterative IEEE-754 single-precision divider, the companion to the pipelined 32-bit multiplier. It decomposes two FP32 operands and computes a/b with a restoring divider that retires one quotient bit per clock. It emits the same expanded internal format the multiplier produces (sign, 8-bit exponent, 48-bit significand with two whole bits), so the result feeds the existing normalize/round stages unchanged. Single-issue with a start/done handshake; new operands are accepted only while the unit is idle or done.

## Interface
- DELAY, 47: number of quotient iterations; fixed by FP32 width; not for override.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; when low, all state and outputs hold
- ld  in  1  start pulse; samples a and b
- a  in  32  dividend (FP32)
- b  in  32  divisor (FP32)
- o  out  57  expanded result {sign, exp[7:0], sig[47:0]}; sig[47:46] are whole bits
- busy  out  1  division in progress
- done  out  1  o and flags valid; held until the next accepted ld
- inf  out  1  result is infinity (overflow or x/0)
- overflow  out  1  exponent overflow
- underflow  out  1  exponent underflow
- dbz  out  1  finite non-zero divided by zero

## Operation
- States:
  - IDLE
  - DIV: 47 cycles, counter counts 46 down to 0.
  - FINAL: 1 cycle.
  - DONE
- Transitions:
  - IDLE or DONE with ld&ce goes to DIV, capturing operands.
  - DIV goes to FINAL when the counter reaches 0.
  - FINAL goes to DONE.
  - ld in DIV or FINAL is ignored.
- Decode uses the existing FP32 decomposer. Denormal operands are flushed to zero. fracta and fractb include the hidden bit, 24 bits each, in [2^23, 2^24).
- Exponent: ex = xa - xb + 127, computed 10-bit signed.
- Quotient: q = floor(fracta·2^46 / fractb), 47 bits, lying in [2^45, 2^47).
  - Each DIV cycle shifts the remainder left, trial-subtracts fractb and shifts in one q bit.
  - The remainder register is 25 bits.
- Normal result: sig = {1'b0, q[46:1], q[0] | (rem≠0)}. The sticky bit is in sig[0]. Value = sig/2^46 · 2^(exp-127).
- Sign = sa^sb for every case, including NaN.
- Special cases, resolved in FINAL, in priority order:
  - a NaN: exp=FF, sig={1,a[22:0],24'b0} with the quiet bit forced.
  - b NaN: same, using b's payload.
  - inf/inf or 0/0: exp=FF, sig={1,23'h400004,24'b0}.
  - a inf: exp=FF, sig=0, inf=1.
  - b zero: exp=FF, sig=0, inf=1, dbz=1.
  - a zero or b inf: exp=0, sig=0.
  - ex≥255: exp=FF, sig=0, overflow=1, inf=1.
  - ex<0: exp=0, sig=0, underflow=1.
- The iteration runs for all inputs; latency is constant.
- Flags and o are cleared at the accepting ld edge and become valid with done.

## Timing
- Reset: state IDLE; o, busy, done, inf, overflow, underflow, dbz all 0. Reset mid-division aborts with no output.
- ld sampled high with ce=1 on edge T:
  - busy=1 after T.
  - DIV iterations occur on edges T+1..T+47.
  - FINAL registers o and flags on edge T+48; done=1 and busy=0 after T+48.
  - Latency is 48 clocks, ld to done.
- Back-to-back: ld may be asserted in the first cycle done is visible. done falls and busy rises after that edge.
- ce low freezes the counter, state and all outputs. Latency is extended by the number of ce-low cycles.

## Structure
- Shared package: FP32 typedef, EMSB=7, FMSB=22, FX=47, the expanded-result typedef (EX=56), the bias constant and the qNaN template.
- The state enum is local to the block.
- Sub-module fp_div_core: restoring radix-2 iteration (remainder, quotient, counter). The top level holds decode, exponent, FSM and the special-case mux.

## Test plan
- 6.0/2.0 (40C00000/40000000) → done after 48 clocks: sign 0, exp 0x80, sig 0x600000000000, all flags 0.
- 1.0/3.0 (3F800000/40400000) → exp 0x7E, sig 0x2AAAAAAAAAAB (sticky set), sign 0.
- -1.0/0 (BF800000/00000000) → sign 1, exp 0xFF, sig 0, inf=1, dbz=1.
- 0/0 → exp 0xFF, sig[47]=1, sig[46:24]=400004.
- NaN 7FA00001 / 1.0 → sig={1,0x600001,24'b0}.
- 7F000000/00800000 → overflow=1, inf=1, exp 0xFF.
- ld pulsed at cycle 10 mid-division → ignored; first result unchanged.
- ce held low 5 cycles mid-division → done at 53 clocks with the same result.
- rst_n asserted mid-division → busy and done drop immediately; a following ld completes normally.
